decodificador_gray_param: RTL and testbench

//  Parametrised Gray-code input decoder. Synchronises and debounces a WIDTH-bit Gray input,

---
 rtl/decodificador_gray_param.sv | 171 +++++++++++++++++
 tb/tb_decodificador_gray_param.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/decodificador_gray_param.sv
// Gray-code input decoder for the board top level.
// Synchronises and debounces a WIDTH-bit Gray input, converts it to binary for the LEDs,
// reports step direction and illegal steps, and scans the value as hex on an
// 8-digit multiplexed 7-segment display.
module decodificador_gray_param #(
   parameter int WIDTH         = 4,
   parameter int STABLE_CYCLES = 4,
   parameter int REFRESH_DIV   = 100000
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] a,
   output logic [WIDTH-1:0] led,
   output logic             led_reset,
   output logic             valid,
   output logic             dir,
   output logic             step_err,
   output logic [7:0]       anodo,
   output logic [6:0]       catodos
);

   localparam int NDIG  = (WIDTH + 3) / 4;
   localparam int PAD_W = NDIG * 4;
   localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
   localparam int REF_W = $clog2(REFRESH_DIV);

   // Input path state
   logic [WIDTH-1:0] sync1_reg, sync2_reg;
   logic [WIDTH-1:0] cand_reg, acc_reg;
   logic [CNT_W-1:0] qual_cnt_reg;
   logic [WIDTH-1:0] led_reg;
   logic             valid_reg, dir_reg, step_err_reg, led_reset_reg;

   // Display scan state
   logic [REF_W-1:0] refresh_cnt_reg, refresh_cnt_next;
   logic [2:0]       idx_reg, idx_next;
   logic             lit_reg, lit_next;
   logic [7:0]       anodo_reg, anodo_next;
   logic [6:0]       catodos_reg, catodos_next;

   logic [WIDTH-1:0] cand_bin;
   logic [WIDTH-1:0] led_inc;
   logic             accept;
   logic             wrap;
   logic [PAD_W-1:0] led_pad;
   logic [3:0]       nib [8];

   // Gray to binary: each binary bit is the XOR of all Gray bits at or above it
   generate
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_g2b
         assign cand_bin[gi] = ^cand_reg[WIDTH-1:gi];
      end
   endgenerate

   assign led_inc = led_reg + WIDTH'(1);
   assign accept  = (qual_cnt_reg == CNT_W'(STABLE_CYCLES)) && (cand_reg != acc_reg);

   // Synchroniser, debounce qualifier and acceptance/decode stage
   always_ff @(posedge clk) begin
      if (!reset) begin
         sync1_reg     <= '0;
         sync2_reg     <= '0;
         cand_reg      <= '0;
         acc_reg       <= '0;
         qual_cnt_reg  <= '0;
         led_reg       <= '0;
         valid_reg     <= 1'b0;
         dir_reg       <= 1'b0;
         step_err_reg  <= 1'b0;
         led_reset_reg <= 1'b1;
      end else begin
         led_reset_reg <= 1'b0;
         sync1_reg     <= a;
         sync2_reg     <= sync1_reg;
         // Any change of the synchronised value restarts qualification
         if (sync2_reg != cand_reg) begin
            cand_reg     <= sync2_reg;
            qual_cnt_reg <= '0;
         end else if (qual_cnt_reg != CNT_W'(STABLE_CYCLES)) begin
            qual_cnt_reg <= qual_cnt_reg + CNT_W'(1);
         end
         valid_reg <= accept;
         if (accept) begin
            acc_reg <= cand_reg;
            led_reg <= cand_bin;
            dir_reg <= (cand_bin == led_inc);
            // Codes always differ here, so not one-hot means more than one bit moved
            if (!$onehot(cand_reg ^ acc_reg))
               step_err_reg <= 1'b1;
         end
      end
   end

   // Nibble per display digit; digits beyond NDIG read as zero
   assign led_pad = PAD_W'(led_reg);
   generate
      for (genvar gi = 0; gi < 8; gi++) begin : g_nib
         if (gi < NDIG) begin : g_used
            assign nib[gi] = led_pad[4*gi +: 4];
         end else begin : g_unused
            assign nib[gi] = 4'h0;
         end
      end
   endgenerate

   function automatic logic [6:0] seg7(input logic [3:0] v);
      logic [6:0] s;
      case (v)
         4'h0: s = 7'b1000000;
         4'h1: s = 7'b1111001;
         4'h2: s = 7'b0100100;
         4'h3: s = 7'b0110000;
         4'h4: s = 7'b0011001;
         4'h5: s = 7'b0010010;
         4'h6: s = 7'b0000010;
         4'h7: s = 7'b1111000;
         4'h8: s = 7'b0000000;
         4'h9: s = 7'b0010000;
         4'hA: s = 7'b0001000;
         4'hB: s = 7'b0000011;
         4'hC: s = 7'b1000110;
         4'hD: s = 7'b0100001;
         4'hE: s = 7'b0000110;
         default: s = 7'b0001110;
      endcase
      return s;
   endfunction

   assign wrap = (refresh_cnt_reg == REF_W'(REFRESH_DIV - 1));

   // Scan next-state: display stays dark until the first refresh period has elapsed
   always_comb begin
      refresh_cnt_next = wrap ? '0 : refresh_cnt_reg + REF_W'(1);
      lit_next         = lit_reg | wrap;
      idx_next         = idx_reg;
      if (wrap && lit_reg)
         idx_next = (idx_reg == 3'(NDIG - 1)) ? 3'd0 : idx_reg + 3'd1;
      anodo_next   = 8'hFF;
      catodos_next = 7'h7F;
      if (lit_next) begin
         anodo_next   = ~(8'd1 << idx_next);
         catodos_next = seg7(nib[idx_next]);
      end
   end

   // Scan registers
   always_ff @(posedge clk) begin
      if (!reset) begin
         refresh_cnt_reg <= '0;
         idx_reg         <= '0;
         lit_reg         <= 1'b0;
         anodo_reg       <= 8'hFF;
         catodos_reg     <= 7'h7F;
      end else begin
         refresh_cnt_reg <= refresh_cnt_next;
         idx_reg         <= idx_next;
         lit_reg         <= lit_next;
         anodo_reg       <= anodo_next;
         catodos_reg     <= catodos_next;
      end
   end

   assign led       = led_reg;
   assign led_reset = led_reset_reg;
   assign valid     = valid_reg;
   assign dir       = dir_reg;
   assign step_err  = step_err_reg;
   assign anodo     = anodo_reg;
   assign catodos   = catodos_reg;

endmodule

// File: tb/tb_decodificador_gray_param.sv
// Scoreboard bench for decodificador_gray_param (WIDTH=4, STABLE_CYCLES=4, REFRESH_DIV=8).
module tb_decodificador_gray_param;

   localparam int W  = 4;
   localparam int SC = 4;
   localparam int RD = 8;

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic [W-1:0] a = '0;
   logic [W-1:0] led;
   logic         led_reset, valid, dir, step_err;
   logic [7:0]   anodo;
   logic [6:0]   catodos;

   decodificador_gray_param #(.WIDTH(W), .STABLE_CYCLES(SC), .REFRESH_DIV(RD)) dut (
      .clk(clk), .reset(reset), .a(a), .led(led), .led_reset(led_reset), .valid(valid),
      .dir(dir), .step_err(step_err), .anodo(anodo), .catodos(catodos)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int         cyc;
      logic [3:0] led;
      logic       dir;
      logic       err;
   } exp_t;

   exp_t       sb[$];
   int         n_vec = 0;
   int         n_err = 0;
   logic [3:0] model_led = 4'h0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic check_reset(input string tag);
      $display("%s: reset state led=%0h valid=%0b dir=%0b err=%0b led_reset=%0b anodo=%0h catodos=%0h",
               tag, led, valid, dir, step_err, led_reset, anodo, catodos);
      chk({tag, "_led"}, 32'(led), 32'h0);
      chk({tag, "_valid"}, 32'(valid), 32'h0);
      chk({tag, "_dir"}, 32'(dir), 32'h0);
      chk({tag, "_step_err"}, 32'(step_err), 32'h0);
      chk({tag, "_led_reset"}, 32'(led_reset), 32'h1);
      chk({tag, "_anodo"}, 32'(anodo), 32'hFF);
      chk({tag, "_catodos"}, 32'(catodos), 32'h7F);
   endtask

   // Drive a Gray code at a falling edge and hold it for 'hold' cycles. The next rising
   // edge samples it; led/valid must change 7 edges later, i.e. at cycle count cyc+8.
   task automatic apply(input logic [3:0] g, input int hold, input bit exp_v,
                        input logic [3:0] l, input logic d, input logic e);
      exp_t x;
      @(negedge clk);
      a = g;
      if (exp_v) begin
         x.cyc = cyc + 8;
         x.led = l;
         x.dir = d;
         x.err = e;
         sb.push_back(x);
         model_led = l;
      end
      $display("drive a=%b hold=%0d expect_valid=%0b led=%0h dir=%0b err=%0b",
               g, hold, exp_v, l, d, e);
      repeat (hold - 1) @(negedge clk);
      if (hold >= 10) chk("led_hold", 32'(led), 32'(model_led));
   endtask

   // Monitor: pop one expectation per valid pulse and compare
   initial begin
      logic prev_v;
      exp_t x;
      prev_v = 1'b0;
      forever begin
         @(negedge clk);
         if (valid === 1'b1) begin
            chk("valid_back_to_back", 32'(prev_v), 32'h0);
            if (sb.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL unexpected_valid: got led=%0h at cycle %0d, expected no pulse", led, cyc);
            end else begin
               x = sb.pop_front();
               $display("valid at cycle %0d: led=%0h dir=%0b err=%0b (exp cycle %0d led=%0h dir=%0b err=%0b)",
                        cyc, led, dir, step_err, x.cyc, x.led, x.dir, x.err);
               chk("valid_cycle", 32'(cyc), 32'(x.cyc));
               chk("led", 32'(led), 32'(x.led));
               chk("dir", 32'(dir), 32'(x.dir));
               chk("step_err", 32'(step_err), 32'(x.err));
            end
         end
         prev_v = valid;
      end
   end

   logic [3:0] gseq [16] = '{4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101,
                             4'b0100, 4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010,
                             4'b1011, 4'b1001, 4'b1000, 4'b0000};

   initial begin
      // Reset held, then first digit must light exactly RD edges after release
      repeat (5) @(negedge clk);
      check_reset("rst1");
      @(negedge clk);
      reset = 1'b1;
      repeat (RD - 1) @(negedge clk);
      chk("led_reset_released", 32'(led_reset), 32'h0);
      chk("anodo_dark_before_refresh", 32'(anodo), 32'hFF);
      @(negedge clk);
      chk("anodo_first_digit", 32'(anodo), 32'hFE);
      chk("catodos_zero", 32'(catodos), 32'h40);

      // Full Gray walk 1..15 then wrap to 0, all +1 steps
      for (int i = 0; i < 16; i++)
         apply(gseq[i], 20, 1'b1, 4'((i + 1) % 16), 1'b1, 1'b0);

      // Step back down: 0 -> 1 -> 2 -> 1
      apply(4'b0001, 20, 1'b1, 4'h1, 1'b1, 1'b0);
      apply(4'b0011, 20, 1'b1, 4'h2, 1'b1, 1'b0);
      apply(4'b0001, 20, 1'b1, 4'h1, 1'b0, 1'b0);

      // Short glitch is ignored; six-cycle pulse qualifies
      apply(4'b0011, 3, 1'b0, 4'h0, 1'b0, 1'b0);
      apply(4'b0001, 20, 1'b0, 4'h0, 1'b0, 1'b0);
      apply(4'b0011, 6, 1'b1, 4'h2, 1'b1, 1'b0);
      apply(4'b0001, 20, 1'b1, 4'h1, 1'b0, 1'b0);

      // Illegal two-bit step sets the sticky error
      apply(4'b0000, 20, 1'b1, 4'h0, 1'b0, 1'b0);
      apply(4'b0011, 20, 1'b1, 4'h2, 1'b0, 1'b1);
      apply(4'b0010, 20, 1'b1, 4'h3, 1'b1, 1'b1);
      apply(4'b0011, 20, 1'b1, 4'h2, 1'b0, 1'b1);

      // Reset clears everything
      @(negedge clk);
      reset = 1'b0;
      a = 4'b0000;
      repeat (5) @(negedge clk);
      check_reset("rst2");
      @(negedge clk);
      reset = 1'b1;
      model_led = 4'h0;
      repeat (10) @(negedge clk);

      // Show 0xA and watch the single-digit display
      apply(4'b1111, 20, 1'b1, 4'hA, 1'b0, 1'b1);
      for (int i = 0; i < 32; i++) begin
         @(negedge clk);
         chk("scan_anodo", 32'(anodo), 32'hFE);
         chk("scan_catodos_A", 32'(catodos), 32'h08);
      end

      // Reset in the middle of qualifying 0xB
      apply(4'b1110, 3, 1'b0, 4'h0, 1'b0, 1'b0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check_reset("rst_mid");
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      begin
         exp_t x;
         x.cyc = cyc + 8;
         x.led = 4'hB;
         x.dir = 1'b0;
         x.err = 1'b1;
         sb.push_back(x);
         model_led = 4'hB;
      end
      repeat (3) @(negedge clk);
      chk("led_zero_after_release", 32'(led), 32'h0);
      repeat (17) @(negedge clk);
      chk("led_requalified", 32'(led), 32'hB);

      chk("scoreboard_drained", 32'(sb.size()), 32'h0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   // Hard time limit so the run always ends
   initial begin
      #200000;
      $display("FAIL timeout: got no finish, expected end of stimulus");
      $fatal(1, "timeout");
   end

endmodule
